// File: rtl/free_list_rrat_pkg.sv
// Shared widths and types for the physical-register free list and retirement RAT.
package free_list_rrat_pkg;

    localparam int REGS     = 32;               // architectural registers
    localparam int PRF      = 64;               // physical registers
    localparam int FLN      = PRF - REGS;       // free-list depth (power of two)
    localparam int PRN_W    = $clog2(PRF);
    localparam int ARN_W    = 5;
    localparam int FL_IDX_W = $clog2(FLN);      // slot index into the free list
    localparam int FL_PTR_W = FL_IDX_W + 1;     // slot index plus wrap bit

    typedef logic [PRN_W-1:0]    prn_t;
    typedef logic [ARN_W-1:0]    arn_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/free_list_rrat_old_prn_fwd.sv
// Per-lane lookup of the PRN superseded by each commit lane. A younger lane
// that writes the same ARN as an older lane in the same group supersedes the
// older lane's PRN, not the stale RRAT entry. ARN 0 frees its own PRN.
module old_prn_fwd
    import free_list_rrat_pkg::*;
#(
    parameter int WAYS = 2
)
(
    input  logic [WAYS-1:0]       commit_valid,
    input  logic [WAYS*ARN_W-1:0] commit_ARN,
    input  logic [WAYS*PRN_W-1:0] commit_PRN,
    input  prn_t                  rrat_prn [WAYS],
    output prn_t                  old_prn  [WAYS]
);

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_lane
            arn_t lane_arn;
            prn_t lane_old;

            assign lane_arn = commit_ARN[gi*ARN_W +: ARN_W];

            // Resolve the old mapping: RRAT, overridden by the youngest older same-ARN lane.
            always_comb begin
                lane_old = rrat_prn[gi];
                for (int j = 0; j < gi; j++) begin
                    if (commit_valid[j] && (commit_ARN[j*ARN_W +: ARN_W] == lane_arn)) begin
                        lane_old = commit_PRN[j*PRN_W +: PRN_W];
                    end
                end
                if (lane_arn == '0) begin
                    lane_old = commit_PRN[gi*PRN_W +: PRN_W];
                end
                if (!commit_valid[gi]) begin
                    lane_old = '0;
                end
            end

            assign old_prn[gi] = lane_old;
        end
    endgenerate

endmodule

// File: rtl/free_list_rrat.sv
// Circular free list of physical registers plus the retirement RAT. Dispatch
// pops from head, commit pushes superseded PRNs at tail, and rhead tracks the
// retirement point so a flush can rewind head and reclaim in-flight PRNs.
module free_list_rrat
    import free_list_rrat_pkg::*;
#(
    parameter int WAYS = 2
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WAYS-1:0]       alloc_req,
    output logic [WAYS*PRN_W-1:0] alloc_PRN,
    output logic [WAYS-1:0]       alloc_gnt,
    output logic [FL_PTR_W-1:0]   num_free,
    input  logic [WAYS-1:0]       commit_valid,
    input  logic [WAYS*ARN_W-1:0] commit_ARN,
    input  logic [WAYS*PRN_W-1:0] commit_PRN,
    input  logic                  proc_nuke,
    output logic [REGS*PRN_W-1:0] rrat_map
);

    prn_t    fl_mem   [FLN];
    prn_t    rrat_reg [REGS];
    fl_ptr_t head_reg, tail_reg, rhead_reg, num_free_reg;
    fl_ptr_t head_next, tail_next, rhead_next, num_free_next;
    fl_ptr_t alloc_cnt, commit_cnt;

    prn_t                rrat_rd    [WAYS];
    prn_t                old_prn    [WAYS];
    logic [FL_IDX_W-1:0] commit_idx [WAYS];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_lane
            logic [FL_IDX_W-1:0] rd_idx;
            arn_t                lane_arn;

            assign rd_idx   = head_reg[FL_IDX_W-1:0] + FL_IDX_W'(gi);
            assign lane_arn = commit_ARN[gi*ARN_W +: ARN_W];
            assign rrat_rd[gi] = rrat_reg[lane_arn];

            // Lane gi is offered the gi-th free PRN; granted only if that many are free.
            assign alloc_PRN[gi*PRN_W +: PRN_W] = fl_mem[rd_idx];
            assign alloc_gnt[gi] = alloc_req[gi] && (fl_ptr_t'(gi) < num_free_reg)
                                   && !proc_nuke && reset;
        end

        for (gi = 0; gi < REGS; gi++) begin : g_map
            assign rrat_map[gi*PRN_W +: PRN_W] = rrat_reg[gi];
        end
    endgenerate

    old_prn_fwd #(.WAYS(WAYS)) u_old_prn_fwd (
        .commit_valid (commit_valid),
        .commit_ARN   (commit_ARN),
        .commit_PRN   (commit_PRN),
        .rrat_prn     (rrat_rd),
        .old_prn      (old_prn)
    );

    assign num_free = num_free_reg;

    // Count grants/commits and give each committing lane its slot behind tail.
    always_comb begin
        alloc_cnt  = '0;
        commit_cnt = '0;
        for (int i = 0; i < WAYS; i++) begin
            commit_idx[i] = tail_reg[FL_IDX_W-1:0] + commit_cnt[FL_IDX_W-1:0];
            alloc_cnt     = alloc_cnt  + fl_ptr_t'(alloc_gnt[i]);
            commit_cnt    = commit_cnt + fl_ptr_t'(commit_valid[i]);
        end
        tail_next     = tail_reg  + commit_cnt;
        rhead_next    = rhead_reg + commit_cnt;
        head_next     = proc_nuke ? rhead_next : (head_reg + alloc_cnt);
        num_free_next = tail_next - head_next;
    end

    // Pointer and free-count registers; a flush rewinds head to the retirement point.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_reg     <= '0;
            rhead_reg    <= '0;
            tail_reg     <= fl_ptr_t'(FLN);
            num_free_reg <= fl_ptr_t'(FLN);
        end else begin
            head_reg     <= head_next;
            rhead_reg    <= rhead_next;
            tail_reg     <= tail_next;
            num_free_reg <= num_free_next;
        end
    end

    // Free-list storage: preload with the non-architectural PRNs, then append freed PRNs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < FLN; k++) begin
                fl_mem[k] <= prn_t'(REGS + k);
            end
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (commit_valid[i]) begin
                    fl_mem[commit_idx[i]] <= old_prn[i];
                end
            end
        end
    end

    // Retirement map: identity at reset; later lanes overwrite earlier ones for the same ARN.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < REGS; k++) begin
                rrat_reg[k] <= prn_t'(k);
            end
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (commit_valid[i] && (commit_ARN[i*ARN_W +: ARN_W] != '0)) begin
                    rrat_reg[commit_ARN[i*ARN_W +: ARN_W]] <= commit_PRN[i*PRN_W +: PRN_W];
                end
            end
        end
    end

endmodule
